enet_ddr_wr_packer: RTL and testbench
=====================================

Name: enet_ddr_wr_packer

Overview:
- Receive-side write stage between the Ethernet MAC read interface (64-bit valid/ready stream at 200 MHz) and the DDR controller write port (256-bit word plus byte enables).
- Gathers four 64-bit beats into one 256-bit DDR word and issues a write request with an incrementing address.
- Handles a partial final word, flags completion, and keeps a cycle-count performance counter for the register file.

Parameters:
- ADDR_INC, 32, byte increment of o_ddr_wr_addr per DDR word issued.
- BEATS_PER_WORD, 4, number of 64-bit beats per DDR word; fixed at 4.

Ports:
- i_clk  in  1  200 MHz clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; latches i_dest_addr and i_data_size and begins a transfer.
- i_dest_addr  in  32  DDR byte address of the first word; 32-byte aligned.
- i_data_size  in  32  bytes to receive; rounded up to a whole number of 8-byte beats.
- i_data  in  64  beat from the MAC read FIFO.
- i_data_valid  in  1  i_data is valid.
- o_core_ready  out  1  packer can accept a beat.
- o_ddr_wr_req  out  1  DDR write request.
- o_ddr_wr_data  out  256  packed write word.
- o_ddr_wr_be  out  32  byte enables; 1 = write the byte.
- o_ddr_wr_addr  out  32  write address.
- i_ddr_wr_ack  in  1  DDR controller accepted the request.
- o_busy  out  1  transfer in progress.
- o_done  out  1  transfer complete; level signal.
- o_rx_cnt  out  32  clock cycles from start to done.

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE, and all internal counters clear. Reset asserted mid-transfer aborts the transfer immediately; no request stays pending.
- Beat count: beats = ceil(i_data_size/8), latched on i_start.
- IDLE:
  - o_core_ready=0.
  - i_start with size 0 goes directly to DONE on the next cycle.
  - i_start with size > 0 goes to FILL. It clears the lane index and o_rx_cnt, loads the address register, and clears o_done.
- FILL:
  - o_core_ready=1.
  - A beat is accepted when i_data_valid && o_core_ready. Beat k of a word goes to bits [64k+63:64k], with BE bits [8k+7:8k] set.
  - Unfilled lanes carry data 0 and BE 0.
  - Go to WRITE when the 4th lane fills or the last beat of the transfer is accepted.
- WRITE:
  - o_core_ready=0.
  - o_ddr_wr_req rises the cycle after the last beat was accepted.
  - data, BE and address stay stable until i_ddr_wr_ack is sampled high.
  - On ack: req drops the next cycle, address += ADDR_INC, and data/BE clear.
  - Next state is FILL if beats remain, otherwise DONE.
  - i_ddr_wr_ack while req=0 is ignored.
- DONE: o_done=1, o_busy=0, then return to IDLE. o_done holds until the next i_start.
- o_busy: 1 in FILL and WRITE.
- o_rx_cnt: increments every cycle while o_busy=1; saturates at 0xFFFFFFFF and holds its value after done.
- i_start while busy: ignored.
- Address wrap: 32-bit modulo wrap, with no error flag.
- Throughput: one word per 4 beats + 1 request cycle + ack latency; no double buffering.

Optional Feature:
- Macro: ENET_DDR_WR_PACKER_BSWAP_EN.
- Defined: each 64-bit beat is byte-reversed before it is packed (i_data[7:0] lands in byte 7 of its lane). This converts network byte order to host order.
- Undefined: beats are packed unmodified. BE and all other behaviour are identical in both builds.

Test Plan:
- Full word: start, addr 0x1000, size 32; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with ack 3 cycles after req.
  - Required: one request with addr 0x1000, data {0x44..,0x33..,0x22..,0x11..}, BE 0xFFFFFFFF.
  - Required: o_done=1, o_rx_cnt equals the measured start-to-done cycles.
- Partial word: size 40 at 0x2000.
  - Required: word 1 at 0x2000 with BE 0xFFFFFFFF.
  - Required: word 2 at 0x2020 with BE 0x000000FF and upper 192 bits 0.
- Odd size: size 13.
  - Required: beats = 2, single write with BE 0x0000FFFF.
- Zero size: size 0.
  - Required: o_done=1 two cycles after start, no o_ddr_wr_req ever asserted.
- Backpressure and reset abort:
  - Hold i_data_valid low intermittently and delay ack by 10 cycles. Required: o_core_ready=0 during WRITE, req and data stable until ack.
  - Assert i_rst mid-FILL. Required: all outputs 0 in the same cycle; a new start after reset behaves normally.
- BSWAP build: beat 0x0102030405060708.
  - Required: lane 0 data is 0x0807060504030201.
  - Without the macro, lane 0 data is 0x0102030405060708.

Source files
------------

// File: rtl/enet_ddr_wr_packer.sv
// ---------------------------------------------------------------------------
// enet_ddr_wr_packer
//
// Receive-side write stage. Gathers BEATS_PER_WORD 64-bit beats from the MAC
// read stream into one 256-bit DDR word. It then issues a write request with
// byte enables and an incrementing address. It also handles a partial final
// word and counts busy cycles for the register file.
//
// Build option: define ENET_DDR_WR_PACKER_BSWAP_EN to byte-reverse every
// 64-bit beat before packing (network -> host order). BE and timing are the
// same in both builds.
//
// Handshakes:
//   beat stream : a beat transfers on a rising edge where i_data_valid and
//                 o_core_ready are both high. i_data is ignored otherwise.
//   ddr write   : o_ddr_wr_req stays high, and data, BE and address stay
//                 stable, until a rising edge that samples i_ddr_wr_ack high.
//                 An ack that arrives while req is low is ignored.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             one-cycle pulse; latches i_dest_addr / i_data_size
//   i_dest_addr[31:0]   DDR byte address of the first word (32-byte aligned)
//   i_data_size[31:0]   bytes to receive, rounded up to whole 8-byte beats
//   i_data[63:0]        beat from the MAC read FIFO
//   i_data_valid        i_data is valid
//   o_core_ready        packer accepts a beat (high only while filling)
//   o_ddr_wr_req        DDR write request
//   o_ddr_wr_data[255:0] packed word; beat k of a word sits in lane k
//   o_ddr_wr_be[31:0]   byte enables; unfilled lanes are 0
//   o_ddr_wr_addr[31:0] write address (wraps modulo 2^32)
//   i_ddr_wr_ack        DDR controller accepted the request
//   o_busy              transfer in progress
//   o_done              transfer complete; held until the next i_start
//   o_rx_cnt[31:0]      busy-cycle count of the last transfer (saturating)
// ---------------------------------------------------------------------------
module enet_ddr_wr_packer #(
  parameter int ADDR_INC       = 32,
  parameter int BEATS_PER_WORD = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [31:0]                 i_dest_addr,
  input  logic [31:0]                 i_data_size,
  input  logic [63:0]                 i_data,
  input  logic                        i_data_valid,
  output logic                        o_core_ready,
  output logic                        o_ddr_wr_req,
  output logic [64*BEATS_PER_WORD-1:0] o_ddr_wr_data,
  output logic [8*BEATS_PER_WORD-1:0]  o_ddr_wr_be,
  output logic [31:0]                 o_ddr_wr_addr,
  input  logic                        i_ddr_wr_ack,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [31:0]                 o_rx_cnt
);

  localparam int WORD_W = 64 * BEATS_PER_WORD;
  localparam int BE_W   = 8 * BEATS_PER_WORD;
  localparam int LANE_W = $clog2(BEATS_PER_WORD);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q;
  logic [31:0]         beats_left_q;
  logic [31:0]         addr_q;
  logic [31:0]         rx_cnt_q;
  logic [WORD_W-1:0]   word_q;
  logic [BE_W-1:0]     be_q;
  logic                done_q;

  logic [63:0]         beat_in;
  logic [32:0]         size_rnd;
  logic [31:0]         beats_total;
  logic                start_ok;
  logic                beat_acc;
  logic                ack_ok;
  logic                word_full;
  logic                last_beat;

  // ceil(size/8), widened so that sizes near 2^32 do not overflow.
  assign size_rnd    = {1'b0, i_data_size} + 33'd7;
  assign beats_total = 32'(size_rnd >> 3);

  assign start_ok  = (state_q == IDLE) && i_start;
  assign beat_acc  = (state_q == FILL) && i_data_valid;
  assign ack_ok    = (state_q == WRITE) && i_ddr_wr_ack;
  assign word_full = (lane_q == LANE_W'(BEATS_PER_WORD - 1));
  assign last_beat = (beats_left_q == 32'd1);

`ifdef ENET_DDR_WR_PACKER_BSWAP_EN
  always_comb begin
    beat_in = '0;
    for (int b = 0; b < 8; b++) begin
      beat_in[8*b +: 8] = i_data[8*(7-b) +: 8];
    end
  end
`else
  assign beat_in = i_data;
`endif

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    o_core_ready = 1'b0;
    o_ddr_wr_req = 1'b0;
    o_busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = (i_data_size == 32'd0) ? DONE : FILL;
      end
      FILL: begin
        o_core_ready = 1'b1;
        o_busy       = 1'b1;
        if (beat_acc && (word_full || last_beat)) state_d = WRITE;
      end
      WRITE: begin
        o_ddr_wr_req = 1'b1;
        o_busy       = 1'b1;
        // beats_left_q already counts down past this word's beats
        if (i_ddr_wr_ack) state_d = (beats_left_q == 32'd0) ? DONE : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: lane packing, address, counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lane_q       <= '0;
      beats_left_q <= '0;
      addr_q       <= '0;
      rx_cnt_q     <= '0;
      word_q       <= '0;
      be_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q       <= i_dest_addr;
        beats_left_q <= beats_total;
        lane_q       <= '0;
        rx_cnt_q     <= '0;
        word_q       <= '0;
        be_q         <= '0;
        done_q       <= 1'b0;
      end
      if (beat_acc) begin
        word_q[lane_q*64 +: 64] <= beat_in;
        be_q[lane_q*8 +: 8]     <= 8'hFF;
        lane_q                  <= lane_q + 1'b1;
        beats_left_q            <= beats_left_q - 32'd1;
      end
      if (ack_ok) begin
        addr_q <= addr_q + 32'(ADDR_INC);
        word_q <= '0;
        be_q   <= '0;
        lane_q <= '0;
      end
      if (state_q == DONE) done_q <= 1'b1;
      if (o_busy && (rx_cnt_q != 32'hFFFF_FFFF)) rx_cnt_q <= rx_cnt_q + 32'd1;
    end
  end

  assign o_ddr_wr_data = word_q;
  assign o_ddr_wr_be   = be_q;
  assign o_ddr_wr_addr = addr_q;
  assign o_done        = done_q;
  assign o_rx_cnt      = rx_cnt_q;

endmodule

// File: tb/tb_enet_ddr_wr_packer.sv
// ---------------------------------------------------------------------------
// tb_enet_ddr_wr_packer
//
// Directed bench for enet_ddr_wr_packer. Each transfer is driven by run_xfer.
// Every observed write request is compared against a hand-written expected
// {addr, be, data} entry in exp_q. Latency, done and rx_cnt are checked
// against hand-computed cycle counts.
// ---------------------------------------------------------------------------
module tb_enet_ddr_wr_packer;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [31:0]  i_dest_addr;
  logic [31:0]  i_data_size;
  logic [63:0]  i_data;
  logic         i_data_valid;
  logic         o_core_ready;
  logic         o_ddr_wr_req;
  logic [255:0] o_ddr_wr_data;
  logic [31:0]  o_ddr_wr_be;
  logic [31:0]  o_ddr_wr_addr;
  logic         i_ddr_wr_ack;
  logic         o_busy;
  logic         o_done;
  logic [31:0]  o_rx_cnt;

  enet_ddr_wr_packer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (i_start),
    .i_dest_addr  (i_dest_addr),
    .i_data_size  (i_data_size),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_core_ready (o_core_ready),
    .o_ddr_wr_req (o_ddr_wr_req),
    .o_ddr_wr_data(o_ddr_wr_data),
    .o_ddr_wr_be  (o_ddr_wr_be),
    .o_ddr_wr_addr(o_ddr_wr_addr),
    .i_ddr_wr_ack (i_ddr_wr_ack),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rx_cnt     (o_rx_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [319:0] exp_q[$];   // {addr[31:0], be[31:0], data[255:0]}
  logic [63:0]  beat_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one transfer. Beats come from beat_q. With gaps set, valid drops
  // every third cycle and stray acks are sent while req is low. The ack is
  // given ack_dly cycles after req is first seen.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] size,
                          input bit gaps, input int ack_dly,
                          output int busy_cyc, output int to_done);
    int idx = 0;
    int age = 0;
    int cyc = 0;
    int n_req = 0;
    int exp_n;
    bit fin = 0;
    logic [319:0] held = '0;
    logic [319:0] cur;
    exp_n    = exp_q.size();
    busy_cyc = 0;
    to_done  = 0;
    @(negedge clk);
    i_start     = 1'b1;
    i_dest_addr = addr;
    i_data_size = size;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      i_start = 1'b0;
      cyc++;
      if (o_done) begin
        fin     = 1;
        to_done = cyc;
        check("busy_at_done", {319'd0, o_busy}, 320'd0);
      end else begin
        if (o_busy) busy_cyc++;
        i_data_valid = 1'b0;
        if (idx < beat_q.size() && !(gaps && (cyc % 3 == 1))) begin
          i_data_valid = 1'b1;
          i_data       = beat_q[idx];
        end
        if (i_data_valid && o_core_ready) idx++;
        i_ddr_wr_ack = 1'b0;
        if (o_ddr_wr_req) begin
          check("ready_in_write", {319'd0, o_core_ready}, 320'd0);
          cur = {o_ddr_wr_addr, o_ddr_wr_be, o_ddr_wr_data};
          if (age == 0) begin
            n_req++;
            held = cur;
            if (exp_q.size() > 0) check("wr_word", cur, exp_q.pop_front());
          end else begin
            check("req_stable", cur, held);
          end
          if (age == ack_dly - 1) i_ddr_wr_ack = 1'b1;
          age++;
        end else begin
          age = 0;
          if (gaps && (cyc % 4 == 0)) i_ddr_wr_ack = 1'b1;
        end
      end
    end
    i_data_valid = 1'b0;
    i_ddr_wr_ack = 1'b0;
    if (!fin) check("done_timeout", 320'd0, 320'd1);
    check("req_count", n_req, exp_n);
    check("exp_drained", exp_q.size(), 0);
    check("done_level", {319'd0, o_done}, 320'd1);
    check("rx_cnt", o_rx_cnt, busy_cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"},
          {o_core_ready, o_ddr_wr_req, o_busy, o_done, o_ddr_wr_addr, o_rx_cnt, o_ddr_wr_be},
          '0);
    check({tag, "_data"}, o_ddr_wr_data, '0);
  endtask

  // ---------------- stimulus ----------------
  int bc, td;
  logic [63:0] lane0;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_dest_addr = '0; i_data_size = '0;
    i_data = '0; i_data_valid = 1'b0; i_ddr_wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full word, ack 3 cycles after req: 4 fill + 3 write cycles busy,
    // done visible 9 sampling cycles after the start edge.
    beat_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    exp_q.push_back({32'h0000_1000, 32'hFFFF_FFFF,
                     64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    run_xfer(32'h0000_1000, 32'd32, 1'b0, 3, bc, td);
    check("full_busy_cycles", bc, 7);
    check("full_to_done", td, 9);

    // Partial word: 5 beats -> full word then a one-lane word
    beat_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5};
    exp_q.push_back({32'h0000_2000, 32'hFFFF_FFFF, 64'hA4, 64'hA3, 64'hA2, 64'hA1});
    exp_q.push_back({32'h0000_2020, 32'h0000_00FF, 192'd0, 64'hA5});
    run_xfer(32'h0000_2000, 32'd40, 1'b0, 1, bc, td);

    // Odd size 13 rounds up to 2 beats
    beat_q = '{64'hC1, 64'hC2};
    exp_q.push_back({32'h0000_3000, 32'h0000_FFFF, 128'd0, 64'hC2, 64'hC1});
    run_xfer(32'h0000_3000, 32'd13, 1'b0, 2, bc, td);

    // Zero size: done two cycles after start, no request
    beat_q = {};
    run_xfer(32'h0000_3800, 32'd0, 1'b0, 1, bc, td);
    check("zero_to_done", td, 2);
    check("zero_busy_cycles", bc, 0);

    // Backpressure: valid gaps, stray acks while req low, ack after 10 cycles
    beat_q = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8};
    exp_q.push_back({32'h0000_4000, 32'hFFFF_FFFF, 64'd4, 64'd3, 64'd2, 64'd1});
    exp_q.push_back({32'h0000_4020, 32'hFFFF_FFFF, 64'd8, 64'd7, 64'd6, 64'd5});
    run_xfer(32'h0000_4000, 32'd64, 1'b1, 10, bc, td);

    // Address wrap at the top of the 32-bit space
    beat_q = '{64'hE1, 64'hE2, 64'hE3, 64'hE4, 64'hE5, 64'hE6, 64'hE7, 64'hE8};
    exp_q.push_back({32'hFFFF_FFE0, 32'hFFFF_FFFF, 64'hE4, 64'hE3, 64'hE2, 64'hE1});
    exp_q.push_back({32'h0000_0000, 32'hFFFF_FFFF, 64'hE8, 64'hE7, 64'hE6, 64'hE5});
    run_xfer(32'hFFFF_FFE0, 32'd64, 1'b0, 2, bc, td);

    // Reset abort mid-FILL: outputs clear in the same cycle
    @(negedge clk);
    i_start = 1'b1; i_dest_addr = 32'h0000_5000; i_data_size = 32'd32;
    @(negedge clk);
    i_start = 1'b0; i_data_valid = 1'b1; i_data = 64'h55;
    @(negedge clk);
    i_data = 64'h56;
    @(negedge clk);
    i_data_valid = 1'b0;
    check("abort_busy_before", {319'd0, o_busy}, 320'd1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;

    beat_q = '{64'h61, 64'h62};
    exp_q.push_back({32'h0000_6000, 32'h0000_FFFF, 128'd0, 64'h62, 64'h61});
    run_xfer(32'h0000_6000, 32'd16, 1'b0, 1, bc, td);
    check("post_reset_cycles", bc, 3);

    // Byte order of a single beat
`ifdef ENET_DDR_WR_PACKER_BSWAP_EN
    lane0 = 64'h0807_0605_0403_0201;
`else
    lane0 = 64'h0102_0304_0506_0708;
`endif
    beat_q = '{64'h0102_0304_0506_0708};
    exp_q.push_back({32'h0000_7000, 32'h0000_00FF, 192'd0, lane0});
    run_xfer(32'h0000_7000, 32'd8, 1'b0, 1, bc, td);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
